// File: rtl/gbe_app_tx_gen.sv
// UDP payload generator for the GbE core's app_tx_* port: bursts of fixed-length patterned packets with a programmable gap.
// Latency: byte issued one edge after an unstalled SEND cycle; afull stalls byte issue. Optional GBE_APP_TX_GEN_SEQ_HDR_EN prefixes seq.
module gbe_app_tx_gen #(
    parameter int MAX_LEN = 1472,
    parameter int GAP_W   = 16
) (
    input  logic             app_clk,
    input  logic             app_rst,
    input  logic             start,
    input  logic             stop,
    input  logic [10:0]      cfg_len,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [31:0]      cfg_count,
    input  logic [31:0]      cfg_destip,
    input  logic [15:0]      cfg_destport,
    output logic [7:0]       app_tx_data,
    output logic             app_tx_dvld,
    output logic             app_tx_eof,
    output logic [31:0]      app_tx_destip,
    output logic [15:0]      app_tx_destport,
    input  logic             app_tx_afull,
    input  logic             app_tx_overflow,
    output logic             busy,
    output logic [31:0]      pkt_sent,
    output logic [15:0]      ovf_cnt
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam logic [10:0] MAX_L = 11'(MAX_LEN);
`ifdef GBE_APP_TX_GEN_SEQ_HDR_EN
    localparam logic [10:0] MIN_L = 11'd4;
`else
    localparam logic [10:0] MIN_L = 11'd1;
`endif

    state_t           state_q, state_d;
    logic [10:0]      len_q, len_d;
    logic [10:0]      idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      destip_q, destip_d;
    logic [15:0]      destport_q, destport_d;
    logic [31:0]      seq_q, seq_d;
    logic             stop_pend_q, stop_pend_d;
    logic [31:0]      pkt_sent_q, pkt_sent_d;
    logic [15:0]      ovf_cnt_q, ovf_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             dvld_q, dvld_d;
    logic             eof_q, eof_d;
    logic             busy_q, busy_d;

    logic        start_ok, issue, is_last, pkt_done, run_end, gap_done;
    logic [31:0] pkt_next;
    logic [10:0] len_clamped;
    logic [7:0]  pattern;

    assign start_ok = (state_q == IDLE) && start && !stop;
    assign issue    = (state_q == SEND) && !app_tx_afull;
    assign is_last  = (idx_q == len_q - 11'd1);
    assign pkt_done = issue && is_last;
    assign pkt_next = pkt_sent_q + 32'd1;
    // A stop arriving on the eof cycle itself ends the run just like a pending one.
    assign run_end  = ((count_q != 32'd0) && (pkt_next == count_q)) || stop_pend_q || stop;
    assign gap_done = (gap_cnt_q == GAP_W'(1));

    assign len_clamped = (cfg_len < MIN_L) ? MIN_L :
                         (cfg_len > MAX_L) ? MAX_L : cfg_len;

`ifdef GBE_APP_TX_GEN_SEQ_HDR_EN
    always_comb begin
        pattern = seq_q[7:0] + idx_q[7:0] - 8'd4;
        if (idx_q < 11'd4) begin
            case (idx_q[1:0])
                2'd0:    pattern = seq_q[31:24];
                2'd1:    pattern = seq_q[23:16];
                2'd2:    pattern = seq_q[15:8];
                default: pattern = seq_q[7:0];
            endcase
        end
    end
`else
    assign pattern = seq_q[7:0] + idx_q[7:0];
`endif

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            count_q     <= '0;
            destip_q    <= '0;
            destport_q  <= '0;
            seq_q       <= '0;
            stop_pend_q <= 1'b0;
            pkt_sent_q  <= '0;
            ovf_cnt_q   <= '0;
            data_q      <= '0;
            dvld_q      <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            count_q     <= count_d;
            destip_q    <= destip_d;
            destport_q  <= destport_d;
            seq_q       <= seq_d;
            stop_pend_q <= stop_pend_d;
            pkt_sent_q  <= pkt_sent_d;
            ovf_cnt_q   <= ovf_cnt_d;
            data_q      <= data_d;
            dvld_q      <= dvld_d;
            eof_q       <= eof_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = SEND;
            SEND: begin
                if (pkt_done) begin
                    if (run_end)                 state_d = IDLE;
                    else if (gap_q != '0)        state_d = GAP;
                    else                         state_d = SEND;
                end
            end
            GAP: begin
                if (stop)          state_d = IDLE;
                else if (gap_done) state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        len_d       = len_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        count_d     = count_q;
        destip_d    = destip_q;
        destport_d  = destport_q;
        seq_d       = seq_q;
        stop_pend_d = stop_pend_q;
        pkt_sent_d  = pkt_sent_q;
        data_d      = data_q;
        dvld_d      = 1'b0;
        eof_d       = 1'b0;
        busy_d      = (state_d != IDLE);

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    len_d       = len_clamped;
                    gap_d       = cfg_gap;
                    count_d     = cfg_count;
                    destip_d    = cfg_destip;
                    destport_d  = cfg_destport;
                    idx_d       = '0;
                    stop_pend_d = 1'b0;
                    pkt_sent_d  = '0;
                end
            end
            SEND: begin
                if (stop) stop_pend_d = 1'b1;
                if (issue) begin
                    data_d = pattern;
                    dvld_d = 1'b1;
                    eof_d  = is_last;
                    if (is_last) begin
                        idx_d      = '0;
                        pkt_sent_d = pkt_next;
                        seq_d      = seq_q + 32'd1;
                        gap_cnt_d  = gap_q;
                        if (run_end) stop_pend_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 11'd1;
                    end
                end
            end
            GAP: gap_cnt_d = gap_cnt_q - GAP_W'(1);
            default: ;
        endcase

        ovf_cnt_d = ovf_cnt_q;
        if (start_ok)
            ovf_cnt_d = '0;
        else if (app_tx_overflow && (ovf_cnt_q != 16'hFFFF))
            ovf_cnt_d = ovf_cnt_q + 16'd1;
    end

    assign app_tx_data     = data_q;
    assign app_tx_dvld     = dvld_q;
    assign app_tx_eof      = eof_q;
    assign app_tx_destip   = destip_q;
    assign app_tx_destport = destport_q;
    assign busy            = busy_q;
    assign pkt_sent        = pkt_sent_q;
    assign ovf_cnt         = ovf_cnt_q;

endmodule

// File: tb/tb_gbe_app_tx_gen.sv
// Bench for gbe_app_tx_gen: randomized configurations checked against a packet-level model of the byte stream.
module tb_gbe_app_tx_gen;

    logic        app_clk = 1'b0;
    logic        app_rst, start, stop;
    logic [10:0] cfg_len;
    logic [15:0] cfg_gap;
    logic [31:0] cfg_count, cfg_destip;
    logic [15:0] cfg_destport;
    logic [7:0]  app_tx_data;
    logic        app_tx_dvld, app_tx_eof;
    logic [31:0] app_tx_destip;
    logic [15:0] app_tx_destport;
    logic        app_tx_afull, app_tx_overflow;
    logic        busy;
    logic [31:0] pkt_sent;
    logic [15:0] ovf_cnt;

    gbe_app_tx_gen #(.MAX_LEN(1472), .GAP_W(16)) dut (
        .app_clk(app_clk), .app_rst(app_rst), .start(start), .stop(stop),
        .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_count(cfg_count),
        .cfg_destip(cfg_destip), .cfg_destport(cfg_destport),
        .app_tx_data(app_tx_data), .app_tx_dvld(app_tx_dvld), .app_tx_eof(app_tx_eof),
        .app_tx_destip(app_tx_destip), .app_tx_destport(app_tx_destport),
        .app_tx_afull(app_tx_afull), .app_tx_overflow(app_tx_overflow),
        .busy(busy), .pkt_sent(pkt_sent), .ovf_cnt(ovf_cnt)
    );

    always #5 app_clk = ~app_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int          viol = 0;
    logic        afull_samp = 1'b0;
    logic [31:0] seq_m = 32'd0;

    logic [7:0]  mon_d[$];
    bit          mon_e[$];
    int unsigned mon_c[$];
    logic [7:0]  exp_d[$];
    bit          exp_e[$];

    always @(posedge app_clk) begin
        cyc        <= cyc + 1;
        afull_samp <= app_tx_afull;
    end

    // A byte is legal only if afull was low when the issuing edge sampled it.
    always @(negedge app_clk) begin
        if (app_tx_dvld === 1'b1) begin
            mon_d.push_back(app_tx_data);
            mon_e.push_back(app_tx_eof === 1'b1);
            mon_c.push_back(cyc);
            if (afull_samp) viol++;
        end
    end

    function automatic int eff_len(input int l);
        int mn;
`ifdef GBE_APP_TX_GEN_SEQ_HDR_EN
        mn = 4;
`else
        mn = 1;
`endif
        if (l < mn) return mn;
        if (l > 1472) return 1472;
        return l;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [31:0] s, input int i);
`ifdef GBE_APP_TX_GEN_SEQ_HDR_EN
        if (i < 4) return 8'(s >> (8 * (3 - i)));
        return 8'(s[7:0] + 8'(i - 4));
`else
        return 8'(s[7:0] + 8'(i));
`endif
    endfunction

    function automatic void build_exp(input int len, input int npk);
        exp_d.delete();
        exp_e.delete();
        for (int p = 0; p < npk; p++)
            for (int i = 0; i < len; i++) begin
                exp_d.push_back(exp_byte(seq_m + 32'(p), i));
                exp_e.push_back(i == len - 1);
            end
    endfunction

    task automatic clear_mon();
        mon_d.delete();
        mon_e.delete();
        mon_c.delete();
    endtask

    task automatic start_run(input int len, input int gap, input int cnt,
                             input logic [31:0] ip, input logic [15:0] port);
        @(posedge app_clk); #1;
        cfg_len = 11'(len); cfg_gap = 16'(gap); cfg_count = 32'(cnt);
        cfg_destip = ip; cfg_destport = port;
        start = 1'b1;
        @(posedge app_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit to);
        to = 1'b1;
        for (int k = 0; k < budget && to; k++) begin
            if (busy === 1'b0) to = 1'b0;
            else begin @(posedge app_clk); #1; end
        end
        @(negedge app_clk); #1;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit to);
        to = 1'b1;
        for (int k = 0; k < budget && to; k++) begin
            if (mon_d.size() >= n) to = 1'b0;
            else begin @(posedge app_clk); #1; end
        end
    endtask

    task automatic test_reset();
        app_rst = 1'b1; start = 0; stop = 0; cfg_len = 0; cfg_gap = 0; cfg_count = 0;
        cfg_destip = 0; cfg_destport = 0; app_tx_afull = 0; app_tx_overflow = 0;
        repeat (3) @(posedge app_clk);
        #1;
        n_cmp++; if ({app_tx_dvld, app_tx_eof, busy} !== 3'b000) begin n_bad++;
            $display("FAIL reset_ctl: got %b want 000", {app_tx_dvld, app_tx_eof, busy}); end
        n_cmp++; if (app_tx_data !== 8'h00) begin n_bad++;
            $display("FAIL reset_data: got %h want 00", app_tx_data); end
        n_cmp++; if ({pkt_sent, ovf_cnt} !== 48'd0) begin n_bad++;
            $display("FAIL reset_cnt: got %h/%h want 0/0", pkt_sent, ovf_cnt); end
        n_cmp++; if ({app_tx_destip, app_tx_destport} !== 48'd0) begin n_bad++;
            $display("FAIL reset_dest: got %h/%h want 0/0", app_tx_destip, app_tx_destport); end
        app_rst = 1'b0;
        seq_m = 32'd0;
    endtask

    task automatic test_back_to_back();
        bit to; int shown = 0;
        logic [31:0] ip = $urandom; logic [15:0] port = 16'($urandom);
        clear_mon();
        start_run(8, 0, 2, ip, port);
        wait_idle(200, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout: got busy stuck want idle"); end
        build_exp(eff_len(8), 2);
        n_cmp++; if (mon_d.size() != exp_d.size()) begin n_bad++;
            $display("FAIL b2b_len: got %0d want %0d", mon_d.size(), exp_d.size()); end
        for (int k = 0; k < mon_d.size() && k < exp_d.size(); k++) begin
            n_cmp++;
            if (mon_d[k] !== exp_d[k] || mon_e[k] !== exp_e[k]) begin n_bad++;
                if (shown++ < 4) $display("FAIL b2b_byte%0d: got %h/%b want %h/%b", k, mon_d[k], mon_e[k], exp_d[k], exp_e[k]); end
        end
        if (mon_c.size() == 16) begin
            n_cmp++; if (mon_c[15] - mon_c[0] !== 15) begin n_bad++;
                $display("FAIL b2b_contig: got span %0d want 15", mon_c[15] - mon_c[0]); end
        end
        n_cmp++; if (pkt_sent !== 32'd2 || busy !== 1'b0) begin n_bad++;
            $display("FAIL b2b_end: got pkt_sent=%0d busy=%b want 2/0", pkt_sent, busy); end
        n_cmp++; if (app_tx_destip !== ip || app_tx_destport !== port) begin n_bad++;
            $display("FAIL b2b_dest: got %h:%h want %h:%h", app_tx_destip, app_tx_destport, ip, port); end
        seq_m += 32'd2;
    endtask

    task automatic test_gap();
        bit to;
        for (int it = 0; it < 3; it++) begin
            int raw = $urandom_range(1, 12);
            int g = $urandom_range(1, 6);
            int l = eff_len(raw);
            int shown = 0;
            clear_mon();
            start_run(raw, g, 3, 32'h0A000001, 16'd1234);
            wait_idle(500, to);
            n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL gap_timeout it%0d: got busy stuck want idle", it); end
            build_exp(l, 3);
            n_cmp++; if (mon_d.size() != exp_d.size()) begin n_bad++;
                $display("FAIL gap_len it%0d: got %0d want %0d", it, mon_d.size(), exp_d.size()); end
            for (int k = 0; k < mon_d.size() && k < exp_d.size(); k++) begin
                n_cmp++;
                if (mon_d[k] !== exp_d[k] || mon_e[k] !== exp_e[k]) begin n_bad++;
                    if (shown++ < 4) $display("FAIL gap_byte%0d: got %h/%b want %h/%b", k, mon_d[k], mon_e[k], exp_d[k], exp_e[k]); end
            end
            if (mon_c.size() == 3 * l) begin
                for (int p = 1; p < 3; p++) begin
                    n_cmp++;
                    if (mon_c[p*l] - mon_c[p*l-1] !== g + 1) begin n_bad++;
                        $display("FAIL gap_idle it%0d: got %0d idle want %0d", it, mon_c[p*l] - mon_c[p*l-1] - 1, g); end
                end
            end
            seq_m += 32'd3;
        end
    endtask

    task automatic test_afull();
        bit to; int v0; int sz0; int shown = 0;
        clear_mon(); v0 = viol;
        start_run(10, 0, 1, 32'h0A000002, 16'd80);
        wait_bytes(2, 50, to);
        sz0 = mon_d.size();
        app_tx_afull = 1'b1;
        repeat (4) begin @(posedge app_clk); #1; end
        n_cmp++; if (mon_d.size() - sz0 > 1) begin n_bad++;
            $display("FAIL afull_extra: got %0d bytes after rise want <=1", mon_d.size() - sz0); end
        app_tx_afull = 1'b0;
        wait_idle(200, to);
        build_exp(eff_len(10), 1);
        seq_m += 32'd1;
        for (int it = 0; it < 2; it++) begin
            int raw = $urandom_range(5, 30);
            clear_mon();
            start_run(raw, $urandom_range(0, 3), 3, 32'h0A000003, 16'd81);
            for (int k = 0; k < 2000 && busy; k++) begin
                app_tx_afull = ($urandom_range(0, 2) == 0);
                @(posedge app_clk); #1;
            end
            app_tx_afull = 1'b0;
            wait_idle(200, to);
            n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL afull_timeout it%0d: got busy stuck want idle", it); end
            build_exp(eff_len(raw), 3);
            n_cmp++; if (mon_d.size() != exp_d.size()) begin n_bad++;
                $display("FAIL afull_len it%0d: got %0d want %0d", it, mon_d.size(), exp_d.size()); end
            for (int k = 0; k < mon_d.size() && k < exp_d.size(); k++) begin
                n_cmp++;
                if (mon_d[k] !== exp_d[k] || mon_e[k] !== exp_e[k]) begin n_bad++;
                    if (shown++ < 4) $display("FAIL afull_byte%0d: got %h/%b want %h/%b", k, mon_d[k], mon_e[k], exp_d[k], exp_e[k]); end
            end
            seq_m += 32'd3;
        end
        n_cmp++; if (viol - v0 !== 0) begin n_bad++;
            $display("FAIL afull_stall: got %0d bytes issued while stalled want 0", viol - v0); end
    endtask

    task automatic test_stop();
        bit to; int shown = 0; int l;
        logic [31:0] ip_a = $urandom;
        clear_mon();
        start_run(20, $urandom_range(0, 3), 0, 32'h0A000004, 16'd82);
        wait_bytes(5, 100, to);
        @(posedge app_clk); #1 stop = 1'b1;
        @(posedge app_clk); #1 stop = 1'b0;
        wait_idle(200, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL stop_timeout: got busy stuck want idle"); end
        build_exp(eff_len(20), 1);
        n_cmp++; if (mon_d.size() != exp_d.size()) begin n_bad++;
            $display("FAIL stop_len: got %0d want %0d", mon_d.size(), exp_d.size()); end
        for (int k = 0; k < mon_d.size() && k < exp_d.size(); k++) begin
            n_cmp++;
            if (mon_d[k] !== exp_d[k] || mon_e[k] !== exp_e[k]) begin n_bad++;
                if (shown++ < 4) $display("FAIL stop_byte%0d: got %h/%b want %h/%b", k, mon_d[k], mon_e[k], exp_d[k], exp_e[k]); end
        end
        n_cmp++; if (pkt_sent !== 32'd1) begin n_bad++; $display("FAIL stop_pkts: got %0d want 1", pkt_sent); end
        seq_m += 32'd1;

        @(posedge app_clk); #1 stop = 1'b1;
        @(posedge app_clk); #1 stop = 1'b0;
        n_cmp++; if (busy !== 1'b0 || pkt_sent !== 32'd1) begin n_bad++;
            $display("FAIL stop_idle: got busy=%b pkt=%0d want 0/1", busy, pkt_sent); end
        @(posedge app_clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge app_clk); #1 start = 1'b0; stop = 1'b0;
        repeat (3) begin @(posedge app_clk); #1; end
        n_cmp++; if (busy !== 1'b0 || pkt_sent !== 32'd1 || mon_d.size() != eff_len(20)) begin n_bad++;
            $display("FAIL start_stop_same: got busy=%b pkt=%0d bytes=%0d want 0/1/%0d", busy, pkt_sent, mon_d.size(), eff_len(20)); end

        l = eff_len(3);
        clear_mon();
        start_run(3, 20, 0, 32'h0A000005, 16'd83);
        wait_bytes(l, 100, to);
        @(posedge app_clk); #1 stop = 1'b1;
        @(posedge app_clk); #1 stop = 1'b0;
        wait_idle(100, to);
        n_cmp++; if (to !== 1'b0 || mon_d.size() != l || pkt_sent !== 32'd1) begin n_bad++;
            $display("FAIL stop_gap: got to=%b bytes=%0d pkt=%0d want 0/%0d/1", to, mon_d.size(), pkt_sent, l); end
        seq_m += 32'd1;

        clear_mon(); shown = 0;
        start_run(6, 2, 2, ip_a, 16'd84);
        repeat (3) begin @(posedge app_clk); #1; end
        cfg_len = 11'd3; cfg_destip = ~ip_a; cfg_count = 32'd5; cfg_gap = 16'd0; start = 1'b1;
        @(posedge app_clk); #1 start = 1'b0;
        wait_idle(200, to);
        build_exp(eff_len(6), 2);
        n_cmp++; if (mon_d.size() != exp_d.size()) begin n_bad++;
            $display("FAIL busy_start_len: got %0d want %0d", mon_d.size(), exp_d.size()); end
        for (int k = 0; k < mon_d.size() && k < exp_d.size(); k++) begin
            n_cmp++;
            if (mon_d[k] !== exp_d[k] || mon_e[k] !== exp_e[k]) begin n_bad++;
                if (shown++ < 4) $display("FAIL busy_start_byte%0d: got %h/%b want %h/%b", k, mon_d[k], mon_e[k], exp_d[k], exp_e[k]); end
        end
        n_cmp++; if (app_tx_destip !== ip_a || pkt_sent !== 32'd2) begin n_bad++;
            $display("FAIL busy_start_cfg: got ip=%h pkt=%0d want %h/2", app_tx_destip, pkt_sent, ip_a); end
        seq_m += 32'd2;
    endtask

    task automatic test_clamp();
        bit to; int shown = 0;
        clear_mon();
        start_run(0, 0, 3, 32'h0A000006, 16'd85);
        wait_idle(100, to);
        build_exp(eff_len(0), 3);
        n_cmp++; if (mon_d.size() != exp_d.size()) begin n_bad++;
            $display("FAIL clamp_lo_len: got %0d want %0d", mon_d.size(), exp_d.size()); end
        for (int k = 0; k < mon_d.size() && k < exp_d.size(); k++) begin
            n_cmp++;
            if (mon_d[k] !== exp_d[k] || mon_e[k] !== exp_e[k]) begin n_bad++;
                if (shown++ < 4) $display("FAIL clamp_lo_byte%0d: got %h/%b want %h/%b", k, mon_d[k], mon_e[k], exp_d[k], exp_e[k]); end
        end
        seq_m += 32'd3;
        clear_mon(); shown = 0;
        start_run(2000, 0, 1, 32'h0A000007, 16'd86);
        wait_idle(3000, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL clamp_hi_timeout: got busy stuck want idle"); end
        build_exp(1472, 1);
        n_cmp++; if (mon_d.size() != exp_d.size()) begin n_bad++;
            $display("FAIL clamp_hi_len: got %0d want %0d", mon_d.size(), exp_d.size()); end
        for (int k = 0; k < mon_d.size() && k < exp_d.size(); k++) begin
            n_cmp++;
            if (mon_d[k] !== exp_d[k] || mon_e[k] !== exp_e[k]) begin n_bad++;
                if (shown++ < 4) $display("FAIL clamp_hi_byte%0d: got %h/%b want %h/%b", k, mon_d[k], mon_e[k], exp_d[k], exp_e[k]); end
        end
        seq_m += 32'd1;
    endtask

    task automatic test_overflow();
        bit to;
        @(posedge app_clk); #1 app_tx_overflow = 1'b1;
        repeat (10) @(posedge app_clk);
        #1;
        n_cmp++; if (ovf_cnt !== 16'd10) begin n_bad++; $display("FAIL ovf_count: got %0d want 10", ovf_cnt); end
        repeat (65530) @(posedge app_clk);
        #1;
        n_cmp++; if (ovf_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL ovf_sat: got %h want ffff", ovf_cnt); end
        app_tx_overflow = 1'b0;
        clear_mon();
        start_run(1, 0, 1, 32'h0A000008, 16'd87);
        n_cmp++; if (ovf_cnt !== 16'd0) begin n_bad++; $display("FAIL ovf_clear: got %h want 0000", ovf_cnt); end
        wait_idle(100, to);
        seq_m += 32'd1;
    endtask

    task automatic test_reset_mid();
        bit to; int eofs = 0; int shown = 0;
        clear_mon();
        start_run(20, 0, 0, 32'h0A000009, 16'd88);
        wait_bytes(3, 50, to);
        @(posedge app_clk); #1 app_rst = 1'b1;
        @(posedge app_clk); #1;
        n_cmp++; if ({app_tx_dvld, app_tx_eof, busy, app_tx_data, pkt_sent, app_tx_destip} !== '0) begin n_bad++;
            $display("FAIL rst_mid: got dvld=%b eof=%b busy=%b data=%h pkt=%0d ip=%h want all 0",
                     app_tx_dvld, app_tx_eof, busy, app_tx_data, pkt_sent, app_tx_destip); end
        app_rst = 1'b0;
        foreach (mon_e[k]) if (mon_e[k]) eofs++;
        n_cmp++; if (eofs !== 0) begin n_bad++; $display("FAIL rst_no_eof: got %0d eofs want 0", eofs); end
        seq_m = 32'd0;
        clear_mon();
        start_run(5, 0, 1, 32'h0A00000A, 16'd89);
        wait_idle(100, to);
        build_exp(eff_len(5), 1);
        n_cmp++; if (mon_d.size() != exp_d.size()) begin n_bad++;
            $display("FAIL rst_seq_len: got %0d want %0d", mon_d.size(), exp_d.size()); end
        for (int k = 0; k < mon_d.size() && k < exp_d.size(); k++) begin
            n_cmp++;
            if (mon_d[k] !== exp_d[k] || mon_e[k] !== exp_e[k]) begin n_bad++;
                if (shown++ < 4) $display("FAIL rst_seq_byte%0d: got %h/%b want %h/%b", k, mon_d[k], mon_e[k], exp_d[k], exp_e[k]); end
        end
        seq_m += 32'd1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_gap();
        test_afull();
        test_stop();
        test_clamp();
        test_reset_mid();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
